// File: rtl/tex_mem_multi_slot.sv
// Texture memory fetch unit: multi-slot dcache request issue, out-of-order response merge, in-order result delivery.
// Lane/texel buses are flattened lane-major: element (lane, texel) sits at index lane*NUM_TEXELS + texel.
module tex_mem_multi_slot #(
  parameter int CORE_ID    = 0,
  parameter int NUM_REQS   = 4,
  parameter int NUM_TEXELS = 4,
  parameter int SLOTS      = 4,
  parameter int REQ_INFOW  = 1,
  localparam int LG   = $clog2(NUM_TEXELS),
  localparam int TB   = (LG > 0) ? LG : 1,
  localparam int SB   = $clog2(SLOTS),
  localparam int LNB  = LG + 1,
  localparam int TAGW = SB + TB
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  input  logic [NUM_REQS-1:0]                req_tmask,
  input  logic [LNB-1:0]                     req_lgntex,
  input  logic [1:0]                         req_lgstride,
  input  logic                               req_signed,
  input  logic [NUM_REQS*32-1:0]             req_baseaddr,
  input  logic [NUM_REQS*NUM_TEXELS*32-1:0]  req_addr,
  input  logic [REQ_INFOW-1:0]               req_info,
  output logic                               req_ready,
  output logic [NUM_REQS-1:0]                dcache_req_valid,
  output logic [NUM_REQS*30-1:0]             dcache_req_addr,
  output logic [NUM_REQS*TAGW-1:0]           dcache_req_tag,
  input  logic [NUM_REQS-1:0]                dcache_req_ready,
  input  logic                               dcache_rsp_valid,
  input  logic [NUM_REQS-1:0]                dcache_rsp_tmask,
  input  logic [NUM_REQS*32-1:0]             dcache_rsp_data,
  input  logic [TAGW-1:0]                    dcache_rsp_tag,
  output logic                               dcache_rsp_ready,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [NUM_REQS-1:0]                rsp_tmask,
  output logic [NUM_REQS*NUM_TEXELS*32-1:0]  rsp_data,
  output logic [REQ_INFOW-1:0]               rsp_info
);
  localparam int CNTW = $clog2(NUM_REQS * NUM_TEXELS + 1);

  logic [SB-1:0]         wr_ptr_q, iss_ptr_q, rd_ptr_q;
  logic [SB:0]           count_q;
  logic [TB-1:0]         tidx_q;
  logic [NUM_REQS-1:0]   sent_q;
  logic [SLOTS-1:0]      valid_q, done_q, ipend_q, sign_q;
  logic [CNTW-1:0]       cnt_q    [SLOTS];
  logic [NUM_REQS-1:0]   tmask_q  [SLOTS];
  logic [TB-1:0]         nlast_q  [SLOTS];
  logic [1:0]            stride_q [SLOTS];
  logic [REQ_INFOW-1:0]  info_q   [SLOTS];
  logic [NUM_TEXELS-1:0] dup_q    [SLOTS];
  logic [29:0]           waddr_q  [SLOTS][NUM_TEXELS][NUM_REQS];
  logic [1:0]            boff_q   [SLOTS][NUM_TEXELS][NUM_REQS];
  logic [31:0]           data_q   [SLOTS][NUM_REQS][NUM_TEXELS];

  logic acc, pop;
  assign req_ready        = (count_q < (SB+1)'(SLOTS));
  assign acc              = req_valid & req_ready;
  assign rsp_valid        = done_q[rd_ptr_q];
  assign pop              = rsp_valid & rsp_ready;
  assign dcache_rsp_ready = 1'b1;
  assign rsp_tmask        = tmask_q[rd_ptr_q];
  assign rsp_info         = info_q[rd_ptr_q];

  // Acceptance: word/byte split, duplicate-address detection and expected response count
  logic [LNB-1:0]        lg_eff;
  logic [TB-1:0]         acc_nlast;
  logic [NUM_TEXELS-1:0] acc_dup;
  logic [CNTW-1:0]       acc_cnt;
  logic [31:0]           acc_full;
  logic [29:0]           acc_waddr [NUM_TEXELS][NUM_REQS];
  logic [1:0]            acc_boff  [NUM_TEXELS][NUM_REQS];

  always_comb begin
    lg_eff    = (req_lgntex > LNB'(LG)) ? LNB'(LG) : req_lgntex;
    acc_nlast = TB'((32'd1 << lg_eff) - 32'd1);
    acc_cnt   = '0;
    acc_full  = '0;
    acc_dup   = '0;
    for (int unsigned t = 0; t < NUM_TEXELS; t++) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        acc_full        = req_baseaddr[i*32 +: 32] + req_addr[(i*NUM_TEXELS+t)*32 +: 32];
        acc_waddr[t][i] = acc_full[31:2];
        acc_boff[t][i]  = acc_full[1:0];
      end
      acc_dup[t] = req_tmask[0];
      for (int unsigned i = 1; i < NUM_REQS; i++)
        if (req_tmask[i] && (acc_waddr[t][i] != acc_waddr[t][0])) acc_dup[t] = 1'b0;
      if (TB'(t) <= acc_nlast)
        acc_cnt = acc_cnt + (acc_dup[t] ? CNTW'(1) : CNTW'($countones(req_tmask)));
    end
  end

  // Issue: one texel of the slot at iss_ptr at a time; ports that already fired are masked by sent_q
  logic                iss_act, tex_done, iss_last;
  logic [NUM_REQS-1:0] iss_need, fire;

  always_comb begin
    iss_act  = ipend_q[iss_ptr_q];
    iss_need = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++)
      iss_need[i] = iss_act & tmask_q[iss_ptr_q][i] & ((i == 0) | ~dup_q[iss_ptr_q][tidx_q]);
    dcache_req_valid = iss_need & ~sent_q;
    fire             = dcache_req_valid & dcache_req_ready;
    tex_done         = iss_act && ((iss_need & ~(sent_q | fire)) == '0);
    iss_last         = (tidx_q == nlast_q[iss_ptr_q]) || (tmask_q[iss_ptr_q] == '0);
  end

  // Response decode and per-lane texel extraction
  logic [SB-1:0]       rs;
  logic [TB-1:0]       rt;
  logic [CNTW-1:0]     dec;
  logic [NUM_REQS-1:0] mrg_en;
  logic [31:0]         mrg_sh  [NUM_REQS];
  logic [31:0]         mrg_val [NUM_REQS];
  assign rs  = dcache_rsp_tag[TAGW-1:TB];
  assign rt  = dcache_rsp_tag[TB-1:0];
  assign dec = CNTW'($countones(dcache_rsp_tmask));

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      // a dup texel is answered on lane 0 only; its data fans out to every active lane
      mrg_en[i] = dcache_rsp_valid & tmask_q[rs][i] &
                  (dup_q[rs][rt] ? dcache_rsp_tmask[0] : dcache_rsp_tmask[i]);
      mrg_sh[i] = ((dup_q[rs][rt] || i == 0) ? dcache_rsp_data[31:0] : dcache_rsp_data[i*32 +: 32])
                  >> {boff_q[rs][rt][i], 3'b000};
      case (stride_q[rs])
        2'd0:    mrg_val[i] = {{24{sign_q[rs] & mrg_sh[i][7]}}, mrg_sh[i][7:0]};
        2'd1:    mrg_val[i] = {{16{sign_q[rs] & mrg_sh[i][15]}}, mrg_sh[i][15:0]};
        default: mrg_val[i] = mrg_sh[i];
      endcase
    end
  end

  always_comb begin
    rsp_data        = '0;
    dcache_req_addr = '0;
    dcache_req_tag  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      for (int unsigned t = 0; t < NUM_TEXELS; t++)
        rsp_data[(i*NUM_TEXELS+t)*32 +: 32] = data_q[rd_ptr_q][i][t];
      dcache_req_addr[i*30 +: 30]    = waddr_q[iss_ptr_q][tidx_q][i];
      dcache_req_tag[i*TAGW +: TAGW] = {iss_ptr_q, tidx_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      iss_ptr_q <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tidx_q    <= '0;
      sent_q    <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      ipend_q   <= '0;
      for (int unsigned s = 0; s < SLOTS; s++) cnt_q[s] <= '0;
    end else begin
      count_q <= count_q + (SB+1)'(acc) - (SB+1)'(pop);
      if (acc) begin
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        valid_q[wr_ptr_q] <= 1'b1;
        ipend_q[wr_ptr_q] <= 1'b1;
        done_q[wr_ptr_q]  <= (acc_cnt == '0);
        cnt_q[wr_ptr_q]   <= acc_cnt;
      end
      if (tex_done) begin
        sent_q <= '0;
        if (iss_last) begin
          tidx_q             <= '0;
          iss_ptr_q          <= iss_ptr_q + 1'b1;
          ipend_q[iss_ptr_q] <= 1'b0;
        end else begin
          tidx_q <= tidx_q + 1'b1;
        end
      end else begin
        sent_q <= sent_q | fire;
      end
      if (dcache_rsp_valid) begin
        cnt_q[rs] <= cnt_q[rs] - dec;
        if (cnt_q[rs] == dec) done_q[rs] <= 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        done_q[rd_ptr_q]  <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      tmask_q[wr_ptr_q]  <= req_tmask;
      nlast_q[wr_ptr_q]  <= acc_nlast;
      stride_q[wr_ptr_q] <= req_lgstride;
      sign_q[wr_ptr_q]   <= req_signed;
      info_q[wr_ptr_q]   <= req_info;
      dup_q[wr_ptr_q]    <= acc_dup;
      for (int unsigned t = 0; t < NUM_TEXELS; t++)
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
          waddr_q[wr_ptr_q][t][i] <= acc_waddr[t][i];
          boff_q[wr_ptr_q][t][i]  <= acc_boff[t][i];
          data_q[wr_ptr_q][i][t]  <= '0;
        end
    end
    for (int unsigned i = 0; i < NUM_REQS; i++)
      if (mrg_en[i]) data_q[rs][i][rt] <= data_q[rs][i][rt] | mrg_val[i];
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && dcache_rsp_valid)
      assert (valid_q[rs] && !done_q[rs] && (rt <= nlast_q[rs]) && (cnt_q[rs] >= dec))
        else $error("tex_mem core %0d: response to non-pending slot %0d texel %0d", CORE_ID, rs, rt);
  end
`endif

endmodule

// File: tb/tb_tex_mem_multi_slot.sv
// Scoreboard bench for tex_mem_multi_slot: reference model of texel fetch, random dcache responder, in-order result monitor.
module tb_tex_mem_multi_slot;
  localparam int NR = 4, NT = 4, SL = 4, IW = 1, TAGW = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic                req_valid = 1'b0;
  logic [NR-1:0]       req_tmask = '0;
  logic [2:0]          req_lgntex = '0;
  logic [1:0]          req_lgstride = '0;
  logic                req_signed = 1'b0;
  logic [NR*32-1:0]    req_baseaddr = '0;
  logic [NR*NT*32-1:0] req_addr = '0;
  logic [IW-1:0]       req_info = '0;
  logic                req_ready;
  logic [NR-1:0]       dcache_req_valid;
  logic [NR*30-1:0]    dcache_req_addr;
  logic [NR*TAGW-1:0]  dcache_req_tag;
  logic [NR-1:0]       dcache_req_ready = '0;
  logic                dcache_rsp_valid = 1'b0;
  logic [NR-1:0]       dcache_rsp_tmask = '0;
  logic [NR*32-1:0]    dcache_rsp_data = '0;
  logic [TAGW-1:0]     dcache_rsp_tag = '0;
  logic                dcache_rsp_ready;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [NR-1:0]       rsp_tmask;
  logic [NR*NT*32-1:0] rsp_data;
  logic [IW-1:0]       rsp_info;

  tex_mem_multi_slot #(.CORE_ID(0), .NUM_REQS(NR), .NUM_TEXELS(NT), .SLOTS(SL), .REQ_INFOW(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tmask(req_tmask), .req_lgntex(req_lgntex), .req_lgstride(req_lgstride),
    .req_signed(req_signed), .req_baseaddr(req_baseaddr), .req_addr(req_addr), .req_info(req_info),
    .req_ready(req_ready),
    .dcache_req_valid(dcache_req_valid), .dcache_req_addr(dcache_req_addr), .dcache_req_tag(dcache_req_tag),
    .dcache_req_ready(dcache_req_ready),
    .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_tmask(dcache_rsp_tmask), .dcache_rsp_data(dcache_rsp_data),
    .dcache_rsp_tag(dcache_rsp_tag), .dcache_rsp_ready(dcache_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_info(rsp_info)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]       tmask;
    logic [NR*NT*32-1:0] data;
    logic [IW-1:0]       info;
    int unsigned         nfire;
    int unsigned         slot;
  } exp_t;
  typedef struct {
    logic [TAGW-1:0] tag;
    int unsigned     lane;
    logic [29:0]     waddr;
  } fire_t;

  exp_t        sb[$];
  fire_t       pend[$];
  int unsigned fires [SL];
  int          checks = 0, failures = 0;
  int unsigned acc_n = 0;
  int          rdy_mode = 0;     // 0 all ready, 1 random, 2 none
  bit          stall_mode = 0, rsp_hold = 0, lifo = 0;

  task automatic check(input string nm, input logic [NR*NT*32-1:0] act, input logic [NR*NT*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (w == 30'h400) return 32'h8001_1234;
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int unsigned ntex_of(input logic [2:0] lg);
    return (lg >= 3'd2) ? 4 : ((lg == 3'd1) ? 2 : 1);
  endfunction

  function automatic logic [NR*NT*32-1:0] model_data(input logic [NR-1:0] tm, input logic [2:0] lg,
      input logic [1:0] st, input logic sg, input logic [NR*32-1:0] base, input logic [NR*NT*32-1:0] off);
    logic [NR*NT*32-1:0] r;
    logic [31:0] a, v;
    r = '0;
    for (int i = 0; i < NR; i++)
      for (int t = 0; t < int'(ntex_of(lg)); t++)
        if (tm[i]) begin
          a = base[i*32 +: 32] + off[(i*NT+t)*32 +: 32];
          v = mem_word(a[31:2]) >> {a[1:0], 3'b000};
          if (st == 2'd0)      v = sg ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
          else if (st == 2'd1) v = sg ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
          r[(i*NT+t)*32 +: 32] = v;
        end
    return r;
  endfunction

  // number of dcache port transactions the request needs: one per texel where all active lanes share lane 0's word
  function automatic int unsigned model_nfire(input logic [NR-1:0] tm, input logic [2:0] lg,
      input logic [NR*32-1:0] base, input logic [NR*NT*32-1:0] off);
    int unsigned n;
    logic dup;
    logic [31:0] a0, ai;
    n = 0;
    for (int t = 0; t < int'(ntex_of(lg)); t++) begin
      a0  = base[31:0] + off[t*32 +: 32];
      dup = tm[0];
      for (int i = 1; i < NR; i++) begin
        ai = base[i*32 +: 32] + off[(i*NT+t)*32 +: 32];
        if (tm[i] && ai[31:2] != a0[31:2]) dup = 1'b0;
      end
      n += dup ? 1 : $countones(tm);
    end
    return n;
  endfunction

  task automatic send(input logic [NR-1:0] tm, input logic [2:0] lg, input logic [1:0] st, input logic sg,
      input logic [NR*32-1:0] base, input logic [NR*NT*32-1:0] off, input logic [IW-1:0] info);
    int unsigned n;
    exp_t e;
    n = 0;
    req_tmask = tm; req_lgntex = lg; req_lgstride = st; req_signed = sg;
    req_baseaddr = base; req_addr = off; req_info = info; req_valid = 1'b1;
    while (!req_ready && n < 3000) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_accept_timeout: req_ready stuck at 0, required 1");
      req_valid = 1'b0;
      return;
    end
    e.tmask = tm; e.info = info; e.slot = acc_n % SL; acc_n++;
    e.data  = model_data(tm, lg, st, sg, base, off);
    e.nfire = model_nfire(tm, lg, base, off);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_first();
    logic [NR*32-1:0] b;
    for (int i = 0; i < NR; i++) b[i*32 +: 32] = 32'h2000 + 32'h40 * i;
    send(4'b1111, 3'd0, 2'd2, 1'b0, b, '0, 1'b1);
    check("first_issue_all_ports", {508'h0, dcache_req_valid}, {508'h0, 4'b1111});
    @(negedge clk);
    check("first_issue_one_cycle", {508'h0, dcache_req_valid}, '0);
  endtask

  task automatic send_random();
    logic [NR*32-1:0] b;
    logic [NR*NT*32-1:0] o;
    logic [31:0] cb, co;
    bit dupm;
    dupm = ($urandom % 3 == 0);
    cb = 32'h4000 + ($urandom & 32'hFFC);
    for (int i = 0; i < NR; i++) begin
      b[i*32 +: 32] = dupm ? cb : 32'h4000 + ($urandom & 32'hFFF);
      for (int t = 0; t < NT; t++) begin
        co = $urandom & 32'hFF;
        o[(i*NT+t)*32 +: 32] = dupm ? ({co[7:2], 2'b00} & 32'h30) + (32'(t) * 32'h40) + 32'($urandom % 4) : co;
      end
    end
    send(($urandom % 8 == 0) ? 4'b0000 : 4'($urandom), 3'($urandom % 4), 2'($urandom), 1'($urandom),
         b, o, 1'($urandom));
  endtask

  // dcache responder: answers earlier port fires in random (or LIFO) order, sometimes merging lanes of one tag
  always @(negedge clk) begin
    fire_t f;
    int unsigned idx;
    logic [NR*32-1:0] d;
    logic [NR-1:0] tm;
    if (reset) begin
      pend.delete();
      dcache_rsp_valid = 1'b0;
      dcache_req_ready = '0;
    end else begin
      dcache_rsp_valid = 1'b0;
      if (!rsp_hold && pend.size() > 0 && ($urandom % 4 != 0)) begin
        idx = lifo ? pend.size() - 1 : $urandom_range(0, pend.size() - 1);
        f = pend[idx];
        pend.delete(idx);
        for (int i = 0; i < NR; i++) d[i*32 +: 32] = $urandom;
        tm = '0;
        tm[f.lane] = 1'b1;
        d[f.lane*32 +: 32] = mem_word(f.waddr);
        if ($urandom % 2 == 0)
          for (int j = pend.size() - 1; j >= 0; j--)
            if (pend[j].tag == f.tag) begin
              tm[pend[j].lane] = 1'b1;
              d[pend[j].lane*32 +: 32] = mem_word(pend[j].waddr);
              pend.delete(j);
            end
        dcache_rsp_valid = 1'b1;
        dcache_rsp_tmask = tm;
        dcache_rsp_data  = d;
        dcache_rsp_tag   = f.tag;
      end
      dcache_req_ready = (rdy_mode == 0) ? '1 : ((rdy_mode == 1) ? NR'($urandom) : '0);
      for (int i = 0; i < NR; i++)
        if (dcache_req_valid[i] && dcache_req_ready[i]) begin
          f.tag = dcache_req_tag[i*TAGW +: TAGW];
          f.lane = i;
          f.waddr = dcache_req_addr[i*30 +: 30];
          pend.push_back(f);
          fires[f.tag[TAGW-1:TAGW-2]]++;
        end
    end
  end

  // result monitor: in-order scoreboard pop plus stability under back-pressure
  bit stalled = 0;
  logic [NR*NT*32-1:0] held_data;
  logic [NR-1:0] held_tmask;
  logic [IW-1:0] held_info;
  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 0;
      rsp_ready = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", {511'h0, rsp_valid}, {511'h0, 1'b1});
        check("hold_data", rsp_data, held_data);
        check("hold_tmask_info", {507'h0, rsp_tmask, rsp_info}, {507'h0, held_tmask, held_info});
      end
      rsp_ready = stall_mode ? ($urandom % 3 == 0) : 1'b1;
      stalled = 0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding, required 0");
          end else begin
            me = sb.pop_front();
            check("rsp_data", rsp_data, me.data);
            check("rsp_tmask", {508'h0, rsp_tmask}, {508'h0, me.tmask});
            check("rsp_info", {511'h0, rsp_info}, {511'h0, me.info});
            check("dcache_fire_count", 512'(fires[me.slot]), 512'(me.nfire));
            fires[me.slot] = 0;
          end
        end else begin
          stalled = 1;
          held_data = rsp_data; held_tmask = rsp_tmask; held_info = rsp_info;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NR*32-1:0] b;
    logic [NR*NT*32-1:0] o;
    for (int s = 0; s < SL; s++) fires[s] = 0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {511'h0, req_ready}, {511'h0, 1'b1});
    check("reset_rsp_valid", {511'h0, rsp_valid}, '0);
    check("reset_dcache_req_valid", {508'h0, dcache_req_valid}, '0);
    reset = 1'b0;
    @(negedge clk);

    send_first();
    drain();

    // all lanes read byte 0x100 for four texels: only port 0 issues
    o = '0;
    for (int k = 0; k < NR*NT; k++) o[k*32 +: 32] = 32'h100;
    send(4'b1111, 3'd2, 2'd0, 1'b0, '0, o, 1'b0);
    check("dup_issue_port0_only", {508'h0, dcache_req_valid}, {508'h0, 4'b0001});
    drain();

    // 16-bit texel at byte offset 2 of word 0x8001_1234, signed then unsigned
    b = '0; b[31:0] = 32'h1000;
    o = '0; o[31:0] = 32'h2;
    send(4'b0001, 3'd0, 2'd1, 1'b1, b, o, 1'b1);
    send(4'b0001, 3'd0, 2'd1, 1'b0, b, o, 1'b0);
    drain();

    // four back-to-back requests answered newest-first
    rsp_hold = 1;
    for (int k = 0; k < SL; k++) send_random();
    check("full_req_ready_low", {511'h0, req_ready}, '0);
    lifo = 1; rsp_hold = 0;
    drain();
    lifo = 0;

    send(4'b0000, 3'd2, 2'd2, 1'b1, '1, '1, 1'b1);
    drain();

    rdy_mode = 1; stall_mode = 1;
    for (int k = 0; k < 60; k++) send_random();
    drain();

    // reset with two requests still in flight
    rdy_mode = 2; rsp_hold = 1; stall_mode = 0;
    send_random();
    send(4'b1011, 3'd1, 2'd2, 1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_req_ready", {511'h0, req_ready}, {511'h0, 1'b1});
    check("midreset_rsp_valid", {511'h0, rsp_valid}, '0);
    check("midreset_dcache_req_valid", {508'h0, dcache_req_valid}, '0);
    sb.delete();
    acc_n = 0;
    for (int s = 0; s < SL; s++) fires[s] = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdy_mode = 0; rsp_hold = 0;
    @(negedge clk);
    send_first();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
